mem_bus_arbiter: RTL

- Shares the CPU's single 13-bit-address / 8-bit-data memory bus between two requesters:
  - port 0: CPU fetch/execute path;
  - port 1: program loader / DMA.
- Sequences every memory access through a request/grant/ack handshake with a programmable number of wait states.
- Sits between the CPU core and the external RAM/ROM; replaces direct rd/wr/addr wiring to memory.

---
 rtl/mem_bus_arbiter_if.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Signal bundle for mem_bus_arbiter: two requester ports plus the shared memory side.
// master = requesters and memory (environment), slave = the arbiter itself.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 8
);
    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              gnt0;
    logic              ack0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              gnt1;
    logic              ack1;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              busy;

    modport master (
        output req0, we0, addr0, wdata0,
        input  gnt0, ack0,
        output req1, we1, addr1, wdata1,
        input  gnt1, ack1,
        input  rdata, mem_addr, mem_wdata, mem_rd, mem_wr, busy,
        output mem_rdata
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        output gnt0, ack0,
        input  req1, we1, addr1, wdata1,
        output gnt1, ack1,
        output rdata, mem_addr, mem_wdata, mem_rd, mem_wr, busy,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter with request/grant/ack handshake and WAIT_CYCLES wait states.
// Optional macro CPU_PRIO_EN: port 0 always wins contention instead of round-robin.
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input logic              clk,
    input logic              rst,
    mem_bus_arbiter_if.slave bus
);
    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e            state_q;
    logic [3:0]        wait_q;
    logic              last_q;
    logic              owner_q;
    logic              mem_we_q;
    logic              gnt0_q, gnt1_q, ack0_q, ack1_q;
    logic              mem_rd_q, mem_wr_q, busy_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata_q;

    logic              pick1;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    always_comb begin
`ifdef CPU_PRIO_EN
        pick1 = bus.req1 && !bus.req0;
`else
        // On contention serve the port that did not win last time.
        pick1 = bus.req1 && (!bus.req0 || !last_q);
`endif
        we_sel    = pick1 ? bus.we1    : bus.we0;
        addr_sel  = pick1 ? bus.addr1  : bus.addr0;
        wdata_sel = pick1 ? bus.wdata1 : bus.wdata0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wait_q      <= 4'd0;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            busy_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req0 || bus.req1) begin
                        owner_q     <= pick1;
                        last_q      <= pick1;
                        mem_we_q    <= we_sel;
                        mem_addr_q  <= addr_sel;
                        mem_wdata_q <= wdata_sel;
                        gnt0_q      <= !pick1;
                        gnt1_q      <= pick1;
                        mem_rd_q    <= !we_sel;
                        mem_wr_q    <= we_sel;
                        wait_q      <= WaitLoad;
                        busy_q      <= 1'b1;
                        state_q     <= StAccess;
                    end
                end
                StAccess: begin
                    if (wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end else begin
                        if (!mem_we_q) begin
                            rdata_q <= bus.mem_rdata;
                        end
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        ack0_q   <= !owner_q;
                        ack1_q   <= owner_q;
                        state_q  <= StDone;
                    end
                end
                StDone: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.busy      = busy_q;
endmodule
